// File: rtl/wb_line_pkg.sv
// wb_line_pkg: shared types, line geometry and byte-select helper for the line master.
package wb_line_pkg;
   typedef enum logic [1:0] {IDLE, RD_BUS, WR_BUS} state_t;
   localparam int LINE_BYTES     = 16;
   localparam int WORDS_PER_LINE = 4;
   function automatic logic [LINE_BYTES-1:0] sel_expand(input logic [3:0] wstrb, input logic [1:0] word_idx);
      return {12'h000, wstrb} << (4 * word_idx);
   endfunction
endpackage

// File: rtl/wb_line_buf.sv
// wb_line_buf: single 128-bit line with tag/valid, fill, byte-merge write and invalidate.
module wb_line_buf
   import wb_line_pkg::*;
(
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_fill,
   input  logic [27:0]           i_fill_tag,
   input  logic [127:0]          i_fill_data,
   input  logic                  i_wr,
   input  logic [27:0]           i_wr_tag,
   input  logic [LINE_BYTES-1:0] i_wr_mask,
   input  logic [127:0]          i_wr_data,
   input  logic                  i_inv,
   input  logic [27:0]           i_lookup_tag,
   output logic                  o_hit,
   output logic [127:0]          o_data
);
   logic         r_valid;
   logic [27:0]  r_tag;
   logic [127:0] r_data;
   logic         w_wr_hit;
   assign w_wr_hit = i_wr && r_valid && r_tag == i_wr_tag;
   assign o_hit    = r_valid && r_tag == i_lookup_tag;
   assign o_data   = r_data;
   // invalidate beats a same-cycle fill, so a flushed fetch never becomes valid
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_valid <= 1'b0;
         r_tag   <= '0;
         r_data  <= '0;
      end else begin
         if (i_fill) begin
            r_tag  <= i_fill_tag;
            r_data <= i_fill_data;
         end else if (w_wr_hit) begin
            for (int b = 0; b < LINE_BYTES; b++)
               if (i_wr_mask[b]) r_data[8*b +: 8] <= i_wr_data[8*b +: 8];
         end
         r_valid <= !i_inv && (i_fill || r_valid);
      end
   end
endmodule

// File: rtl/wb_line_master.sv
// wb_line_master: 32-bit CPU port to 128-bit Wishbone master with a one-line read buffer,
// write-through stores, one outstanding bus cycle and ack timeout.
module wb_line_master
   import wb_line_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
)(
   input  logic         wb_clk_i,
   input  logic         wb_rst_i,
   input  logic         cpu_req_valid,
   output logic         cpu_req_ready,
   input  logic         cpu_we,
   input  logic [31:0]  cpu_addr,
   input  logic [3:0]   cpu_wstrb,
   input  logic [31:0]  cpu_wdata,
   output logic         cpu_rsp_valid,
   output logic         cpu_rsp_err,
   output logic [31:0]  cpu_rdata,
   input  logic         flush_i,
   output logic         wbm_cyc_o,
   output logic         wbm_stb_o,
   output logic         wbm_we_o,
   output logic [31:0]  wbm_adr_o,
   output logic [15:0]  wbm_sel_o,
   output logic [127:0] wbm_dat_o,
   input  logic [127:0] wbm_dat_i,
   input  logic         wbm_ack_i,
   input  logic         wbm_err_i
);
   localparam int CW = (TO_W < 1) ? 1 : TO_W;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] CNT_MAX  = '1;
   state_t                              r_state, w_state_nxt;
   logic                                r_we;
   logic [31:0]                         r_adr;
   logic [15:0]                         r_sel;
   logic [127:0]                        r_dat;
   logic [$clog2(WORDS_PER_LINE)-1:0]   r_word;
   logic [CW-1:0]                       r_cnt;
   logic                                r_rsp_valid, r_rsp_err;
   logic [31:0]                         r_rdata;
   logic                                w_bus, w_accept, w_hit, w_go, w_ack, w_err, w_to, w_end;
   logic                                w_buf_hit;
   logic [127:0]                        w_line;
   logic                                w_unused;
   assign w_unused = ^cpu_addr[1:0];
   assign w_bus    = r_state != IDLE;
   always_comb begin
      w_accept    = cpu_req_valid && r_state == IDLE && !wb_rst_i;
      w_hit       = w_accept && !cpu_we && w_buf_hit;
      w_go        = w_accept && !w_hit;
      w_err       = w_bus && wbm_err_i;
      w_ack       = w_bus && wbm_ack_i && !wbm_err_i;
      w_to        = w_bus && !wbm_ack_i && !wbm_err_i && TIMEOUT_CYCLES != 0 && r_cnt == CNT_LAST;
      w_end       = w_err || w_ack || w_to;
      w_state_nxt = w_end ? IDLE : !w_go ? r_state : cpu_we ? WR_BUS : RD_BUS;
   end
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) r_state <= IDLE;
      else          r_state <= w_state_nxt;
   end
   wb_line_buf u_buf (
      .i_clk        (wb_clk_i),
      .i_rst        (wb_rst_i),
      .i_fill       (w_ack && r_state == RD_BUS),
      .i_fill_tag   (r_adr[31:4]),
      .i_fill_data  (wbm_dat_i),
      .i_wr         (w_ack && r_state == WR_BUS),
      .i_wr_tag     (r_adr[31:4]),
      .i_wr_mask    (r_sel),
      .i_wr_data    (r_dat),
      .i_inv        (flush_i || ((w_err || w_to) && r_state == RD_BUS)),
      .i_lookup_tag (cpu_addr[31:4]),
      .o_hit        (w_buf_hit),
      .o_data       (w_line)
   );
   // bus fields are captured once at acceptance and held for the whole cycle
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_we        <= 1'b0;
         r_adr       <= '0;
         r_sel       <= '0;
         r_dat       <= '0;
         r_word      <= '0;
         r_cnt       <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rdata     <= '0;
      end else begin
         r_rsp_valid <= w_hit || w_end;
         r_rsp_err   <= w_err || w_to;
         r_rdata     <= w_hit ? w_line[32*cpu_addr[3:2] +: 32] :
                        (w_ack && !r_we) ? wbm_dat_i[32*r_word +: 32] : '0;
         if (w_go) begin
            r_we   <= cpu_we;
            r_adr  <= {cpu_addr[31:4], 4'h0};
            r_sel  <= cpu_we ? sel_expand(cpu_wstrb, cpu_addr[3:2]) : 16'hFFFF;
            r_dat  <= cpu_we ? {4{cpu_wdata}} : '0;
            r_word <= cpu_addr[3:2];
            r_cnt  <= '0;
         end else if (w_bus && r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end
   assign cpu_req_ready = r_state == IDLE && !wb_rst_i;
   assign cpu_rsp_valid = r_rsp_valid && !wb_rst_i;
   assign cpu_rsp_err   = r_rsp_err && !wb_rst_i;
   assign cpu_rdata     = wb_rst_i ? '0 : r_rdata;
   assign wbm_cyc_o     = w_bus && !wb_rst_i;
   assign wbm_stb_o     = w_bus && !wb_rst_i;
   assign wbm_we_o      = r_we && !wb_rst_i;
   assign wbm_adr_o     = wb_rst_i ? '0 : r_adr;
   assign wbm_sel_o     = wb_rst_i ? '0 : r_sel;
   assign wbm_dat_o     = wb_rst_i ? '0 : r_dat;
endmodule

// File: tb/tb_wb_line_master.sv
// tb_wb_line_master: scoreboarded random and directed test of wb_line_master against a
// memory-plus-buffered-tag reference model and a scripted Wishbone slave.
module tb_wb_line_master;
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         cpu_req_valid = 1'b1, cpu_req_ready, cpu_we = 1'b0;
   logic [31:0]  cpu_addr = 32'h1234_5678, cpu_wdata = 32'h0;
   logic [3:0]   cpu_wstrb = 4'h0;
   logic         cpu_rsp_valid, cpu_rsp_err, flush_i = 1'b0;
   logic [31:0]  cpu_rdata;
   logic         wbm_cyc_o, wbm_stb_o, wbm_we_o;
   logic [31:0]  wbm_adr_o;
   logic [15:0]  wbm_sel_o;
   logic [127:0] wbm_dat_o, wbm_dat_i;
   logic         wbm_ack_i, wbm_err_i;

   always #5 clk = ~clk;

   wb_line_master #(.TIMEOUT_CYCLES(16)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_we(cpu_we),
      .cpu_addr(cpu_addr), .cpu_wstrb(cpu_wstrb), .cpu_wdata(cpu_wdata),
      .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_err(cpu_rsp_err), .cpu_rdata(cpu_rdata),
      .flush_i(flush_i),
      .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
      .wbm_adr_o(wbm_adr_o), .wbm_sel_o(wbm_sel_o), .wbm_dat_o(wbm_dat_o),
      .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i)
   );

   typedef struct packed {logic err; logic [31:0] data;} rsp_t;
   rsp_t         exp_q[$];
   rsp_t         mon_e;
   int           checks = 0, failures = 0;
   logic [127:0] mem [logic [27:0]];
   logic         ref_valid = 1'b0;
   logic [27:0]  ref_tag = '0;
   // expectations handed from the driver to the slave for the next bus cycle
   logic         bus_exp = 1'b0, exp_we = 1'b0;
   logic [31:0]  exp_adr = '0;
   logic [15:0]  exp_sel = '0;
   logic [127:0] exp_dat = '0;
   int           mode = 0, delay = 0;

   function automatic logic [127:0] get_line(logic [27:0] t);
      return mem.exists(t) ? mem[t] : {4'hA, t, 4'hB, t, 4'hC, t, 4'hD, t};
   endfunction

   task automatic check(string name, logic [127:0] act, logic [127:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && cpu_rsp_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_rsp: got rsp err=%0b rdata=%0h expected none", cpu_rsp_err, cpu_rdata);
         end else begin
            mon_e = exp_q.pop_front();
            check("rsp_err", 128'(cpu_rsp_err), 128'(mon_e.err));
            check("rsp_rdata", 128'(cpu_rdata), 128'(mon_e.data));
         end
      end
   end

   task automatic bus_txn();
      logic [31:0]  a = wbm_adr_o;
      logic [15:0]  s = wbm_sel_o;
      logic         w = wbm_we_o;
      logic [127:0] dd = wbm_dat_o;
      logic         e = bus_exp;
      logic         stable = 1'b1;
      int           m = mode, d = delay, n = 0;
      bus_exp = 1'b0;
      check("bus_expected", 128'(e), 128'(1));
      check("bus_adr", 128'(a), 128'(exp_adr));
      check("bus_sel", 128'(s), 128'(exp_sel));
      check("bus_we", 128'(w), 128'(exp_we));
      if (exp_we) check("bus_dat", dd, exp_dat);
      while (wbm_cyc_o && n < 200) begin
         if (wbm_stb_o !== 1'b1 || wbm_adr_o !== a || wbm_sel_o !== s || wbm_we_o !== w || wbm_dat_o !== dd)
            stable = 1'b0;
         if (m < 2 && n == d) begin
            wbm_ack_i = (m == 0);
            wbm_err_i = (m == 1);
            wbm_dat_i = (m == 0) ? get_line(a[31:4]) : {4{$urandom()}};
         end else begin
            wbm_ack_i = 1'b0;
            wbm_err_i = 1'b0;
         end
         @(negedge clk);
         n++;
      end
      wbm_ack_i = 1'b0;
      wbm_err_i = 1'b0;
      check("bus_stable", 128'(stable), 128'(1));
      if (m < 2) check("bus_len", 128'(n), 128'(d + 1));
      if (m == 2) check("timeout_len", 128'(n), 128'(16));
   endtask

   initial begin
      wbm_ack_i = 1'b0;
      wbm_err_i = 1'b0;
      wbm_dat_i = '0;
      forever begin
         @(negedge clk);
         if (wbm_cyc_o) bus_txn();
      end
   end

   // m: 0 ack after d cycles, 1 err after d cycles, 2 never ack (timeout), 3 never ack (reset test)
   task automatic issue(logic we, logic [31:0] addr, logic [3:0] strb, logic [31:0] wdata, int m, int d, logic fl);
      int           n = 0;
      int           w = int'(addr[3:2]);
      logic [27:0]  t = addr[31:4];
      logic [127:0] line;
      logic         hit;
      rsp_t         r;
      @(negedge clk);
      while (!cpu_req_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!cpu_req_ready) begin
         checks++;
         failures++;
         $display("FAIL ready_wait: got ready=0 for %0d cycles expected ready=1", n);
         return;
      end
      check("bus_missing", 128'(bus_exp), 128'(0));
      line = get_line(t);
      hit = !we && ref_valid && ref_tag == t;
      if (fl) ref_valid = 1'b0;
      if (hit) begin
         r.err = 1'b0;
         r.data = line[32*w +: 32];
      end else begin
         exp_adr = {t, 4'h0};
         exp_we = we;
         exp_sel = 16'h0;
         for (int b = 0; b < 4; b++) exp_sel[4*w+b] = strb[b];
         if (!we) exp_sel = 16'hFFFF;
         exp_dat = {4{wdata}};
         mode = m;
         delay = d;
         bus_exp = 1'b1;
         r.err = (m != 0);
         r.data = 32'h0;
         if (m != 0) begin
            if (!we) ref_valid = 1'b0;
         end else if (we) begin
            for (int b = 0; b < 4; b++) if (strb[b]) line[32*w+8*b +: 8] = wdata[8*b +: 8];
            mem[t] = line;
         end else begin
            r.data = line[32*w +: 32];
            ref_valid = 1'b1;
            ref_tag = t;
         end
      end
      exp_q.push_back(r);
      cpu_we = we;
      cpu_addr = addr;
      cpu_wstrb = strb;
      cpu_wdata = wdata;
      flush_i = fl;
      cpu_req_valid = 1'b1;
      @(posedge clk);
      #1;
      cpu_req_valid = 1'b0;
      flush_i = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("drain_empty", 128'(exp_q.size()), 128'(0));
      @(negedge clk);
      check("drain_bus_missing", 128'(bus_exp), 128'(0));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish before 1ms");
      $fatal(1);
   end

   initial begin
      mem[28'h0000100] = 128'h33333333_22222222_11111111_00000000;
      repeat (3) begin
         @(negedge clk);
         check("reset_outputs",
               {cpu_req_ready, cpu_rsp_valid, cpu_rsp_err, cpu_rdata, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_sel_o},
               128'(0));
         check("reset_dat_o", wbm_dat_o, 128'(0));
      end
      rst = 1'b0;
      cpu_req_valid = 1'b0;
      @(negedge clk);
      check("ready_after_reset", 128'(cpu_req_ready), 128'(1));
      issue(1'b0, 32'h0000_1008, 4'h0, 32'h0, 0, 5, 1'b0);
      issue(1'b0, 32'h0000_100C, 4'h0, 32'h0, 0, 0, 1'b0);
      issue(1'b1, 32'h0000_1004, 4'b0011, 32'hAABBCCDD, 0, 2, 1'b0);
      issue(1'b0, 32'h0000_1004, 4'h0, 32'h0, 0, 0, 1'b0);
      issue(1'b1, 32'h0000_1004, 4'b1111, 32'h12345678, 1, 3, 1'b0);
      issue(1'b0, 32'h0000_1004, 4'h0, 32'h0, 0, 0, 1'b0);
      issue(1'b0, 32'h0000_1000, 4'h0, 32'h0, 0, 0, 1'b1);
      issue(1'b0, 32'h0000_1004, 4'h0, 32'h0, 0, 1, 1'b0);
      issue(1'b0, 32'h0000_2000, 4'h0, 32'h0, 2, 0, 1'b0);
      issue(1'b0, 32'h0000_2004, 4'h0, 32'h0, 0, 0, 1'b0);
      drain();
      issue(1'b0, 32'h0000_3000, 4'h0, 32'h0, 3, 0, 1'b0);
      repeat (5) @(negedge clk);
      check("mid_read_cyc", 128'(wbm_cyc_o), 128'(1));
      rst = 1'b1;
      exp_q.delete();
      ref_valid = 1'b0;
      @(negedge clk);
      check("rst_cyc_low", 128'(wbm_cyc_o), 128'(0));
      check("rst_no_rsp", 128'(cpu_rsp_valid), 128'(0));
      rst = 1'b0;
      issue(1'b0, 32'h0000_3008, 4'h0, 32'h0, 0, 2, 1'b0);
      for (int i = 0; i < 400; i++) begin
         logic [31:0] a;
         int          p, m;
         a = 32'h4000 + ($urandom_range(0, 3) << 4) + ($urandom_range(0, 3) << 2) + $urandom_range(0, 3);
         p = int'($urandom_range(0, 99));
         m = (p < 8) ? 1 : (p < 12) ? 2 : 0;
         issue($urandom_range(0, 2) == 0, a, 4'($urandom()), $urandom(), m,
               int'($urandom_range(0, 6)), $urandom_range(0, 15) == 0);
      end
      drain();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
